// File: rtl/pe_set_ctrl_pkg.sv
// pe_set_ctrl_pkg: shared types for the PE set configuration sequencer.
// Holds the state enum, error codes and a wait-state helper.
package pe_set_ctrl_pkg;

    localparam int ERR_W = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_WAIT,
        S_FLUSH_TAG,
        S_TAG_WAIT,
        S_FLUSH_KER,
        S_KER_WAIT,
        S_RUN,
        S_DONE,
        S_ERR
    } ctrl_state_t;

    typedef enum logic [ERR_W-1:0] {
        NONE    = 3'd0,
        BAD_CFG = 3'd1,
        RST_TO  = 3'd2,
        TAG_TO  = 3'd3,
        KER_TO  = 3'd4,
        ABORT   = 3'd5
    } err_code_t;

    function automatic logic is_wait(ctrl_state_t s);
        return (s == S_RST_WAIT) || (s == S_TAG_WAIT) || (s == S_KER_WAIT);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer: saturating cycles-in-state counter shared by all wait states.
// Ports: clk/rstn, clr_i (state entry), en_i (in state) -> min_ok_o, expired_o.
module wait_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic min_ok_o,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAX = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count equals the number of cycles spent in the current wait
    // state including this one, so the entry edge loads 1, not 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CW'(1);
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign min_ok_o  = (cnt_q >= CW'(2));
    assign expired_o = (cnt_q == MAX);

endmodule

// File: rtl/pe_set_cfg_ctrl.sv
// pe_set_cfg_ctrl: bring-up and run sequencer for the global PE set.
// In: start/cfg_*, abort, *_busy, beat. Out: flush pulses, latched cfg, run/busy/done/err.
module pe_set_cfg_ctrl
    import pe_set_ctrl_pkg::*;
#(
    parameter int NUM_ROW = 10,
    parameter int TIMEOUT = 1024,
    parameter int RUN_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [7:0]       cfg_kernel_size,
    input  logic             cfg_external,
    input  logic [RUN_W-1:0] cfg_run_len,
    input  logic             abort,
    input  logic             rst_busy,
    input  logic             tag_busy,
    input  logic             kernel_busy,
    input  logic             beat,
    output logic             flush_tag,
    output logic             flush_kernel,
    output logic [7:0]       kernel_size,
    output logic             external,
    output logic             run_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_code
);

    localparam logic [7:0] MAX_KS = 8'(NUM_ROW);

    ctrl_state_t      state_q, state_d;
    err_code_t        err_code_q, err_code_d;
    logic [7:0]       ks_q, ks_d;
    logic             ext_q, ext_d;
    logic [RUN_W-1:0] len_q, len_d;
    logic [RUN_W-1:0] cnt_q, cnt_d;
    logic             abort_err_q, abort_err_d;

    logic cfg_ok;
    logic last_beat;
    logic tmr_clr;
    logic tmr_en;
    logic min_ok;
    logic expired;

    assign cfg_ok = (cfg_kernel_size != 8'd0) && (cfg_kernel_size <= MAX_KS);

    // len_q is non-zero in RUN, so len_q-1 cannot underflow and the
    // counter never needs to reach 2^RUN_W.
    assign last_beat = (cnt_q == (len_q - RUN_W'(1)));

    assign tmr_clr = is_wait(state_d) && (state_d != state_q);
    assign tmr_en  = is_wait(state_q);

    wait_timer #(
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .min_ok_o (min_ok),
        .expired_o(expired)
    );

    always_comb begin
        state_d     = state_q;
        err_code_d  = err_code_q;
        ks_d        = ks_q;
        ext_d       = ext_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        abort_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        ks_d       = cfg_kernel_size;
                        ext_d      = cfg_external;
                        len_d      = cfg_run_len;
                        cnt_d      = '0;
                        err_code_d = NONE;
                        state_d    = S_RST_WAIT;
                    end else begin
                        err_code_d = BAD_CFG;
                        state_d    = S_ERR;
                    end
                end
            end
            S_RST_WAIT: begin
                if (!rst_busy) begin
                    state_d = S_FLUSH_TAG;
                end else if (expired) begin
                    err_code_d = RST_TO;
                    state_d    = S_ERR;
                end
            end
            S_FLUSH_TAG: state_d = S_TAG_WAIT;
            // Busy may rise one cycle after the flush, so it is only
            // trusted from the second wait cycle on.
            S_TAG_WAIT: begin
                if (min_ok && !tag_busy) begin
                    state_d = S_FLUSH_KER;
                end else if (expired) begin
                    err_code_d = TAG_TO;
                    state_d    = S_ERR;
                end
            end
            S_FLUSH_KER: state_d = S_KER_WAIT;
            S_KER_WAIT: begin
                if (min_ok && !kernel_busy) begin
                    state_d = (len_q == '0) ? S_DONE : S_RUN;
                end else if (expired) begin
                    err_code_d = KER_TO;
                    state_d    = S_ERR;
                end
            end
            S_RUN: begin
                if (beat) begin
                    cnt_d = cnt_q + RUN_W'(1);
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a start accepted in IDLE.
        if (abort) begin
            state_d     = S_IDLE;
            err_code_d  = ABORT;
            ks_d        = ks_q;
            ext_d       = ext_q;
            len_d       = len_q;
            cnt_d       = cnt_q;
            abort_err_d = (state_q != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            err_code_q  <= NONE;
            ks_q        <= '0;
            ext_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            abort_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_code_q  <= err_code_d;
            ks_q        <= ks_d;
            ext_q       <= ext_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            abort_err_q <= abort_err_d;
        end
    end

    assign flush_tag    = (state_q == S_FLUSH_TAG);
    assign flush_kernel = (state_q == S_FLUSH_KER);
    assign run_en       = (state_q == S_RUN);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERR) || abort_err_q;
    assign kernel_size  = ks_q;
    assign external     = ext_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_pe_set_cfg_ctrl.sv
// tb_pe_set_cfg_ctrl: directed self-checking bench for pe_set_cfg_ctrl.
// Built with TIMEOUT=16 so the timeout paths stay short.
module tb_pe_set_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  cfg_kernel_size;
    logic        cfg_external;
    logic [15:0] cfg_run_len;
    logic        abort;
    logic        rst_busy;
    logic        tag_busy;
    logic        kernel_busy;
    logic        beat;
    logic        flush_tag;
    logic        flush_kernel;
    logic [7:0]  kernel_size;
    logic        external;
    logic        run_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;

    int checks   = 0;
    int failures = 0;

    pe_set_cfg_ctrl #(
        .NUM_ROW(10),
        .TIMEOUT(16),
        .RUN_W  (16)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .cfg_kernel_size(cfg_kernel_size),
        .cfg_external   (cfg_external),
        .cfg_run_len    (cfg_run_len),
        .abort          (abort),
        .rst_busy       (rst_busy),
        .tag_busy       (tag_busy),
        .kernel_busy    (kernel_busy),
        .beat           (beat),
        .flush_tag      (flush_tag),
        .flush_kernel   (flush_kernel),
        .kernel_size    (kernel_size),
        .external       (external),
        .run_en         (run_en),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] ks, input logic ext, input logic [15:0] len);
        cfg_kernel_size = ks;
        cfg_external    = ext;
        cfg_run_len     = len;
        start           = 1'b1;
        tick();
        start           = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b0; cfg_kernel_size = 8'd0; cfg_external = 1'b0;
        cfg_run_len = 16'd0; abort = 1'b0; rst_busy = 1'b0;
        tag_busy = 1'b0; kernel_busy = 1'b0; beat = 1'b0;
        tick(); tick();
        checks++;
        if ({flush_tag, flush_kernel, run_en, busy, done, err, external} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctl got %b exp 0",
                {flush_tag, flush_kernel, run_en, busy, done, err, external});
        end
        checks++;
        if ({kernel_size, err_code} !== 11'd0) begin
            failures++;
            $display("FAIL reset_vals ks=%0d code=%0d exp 0", kernel_size, err_code);
        end
        #2 rstn = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        issue(8'd3, 1'b1, 16'd4);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (flush_tag !== (c == 2)) begin
                failures++;
                $display("FAIL nom_flush_tag c=%0d got %b exp %b", c, flush_tag, c == 2);
            end
            checks++;
            if (flush_kernel !== (c == 5)) begin
                failures++;
                $display("FAIL nom_flush_ker c=%0d got %b exp %b", c, flush_kernel, c == 5);
            end
            checks++;
            if (run_en !== (c == 8)) begin
                failures++;
                $display("FAIL nom_run_en c=%0d got %b exp %b", c, run_en, c == 8);
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL nom_busy c=%0d got %b exp 1", c, busy);
            end
            if (c < 8) tick();
        end
        checks++;
        if (kernel_size !== 8'd3 || external !== 1'b1) begin
            failures++;
            $display("FAIL nom_cfg ks=%0d ext=%b exp 3/1", kernel_size, external);
        end
        for (int c = 8; c <= 13; c++) begin
            beat = (c != 10) && (c <= 12);
            checks++;
            if (done !== (c == 13)) begin
                failures++;
                $display("FAIL nom_done c=%0d got %b exp %b", c, done, c == 13);
            end
            checks++;
            if (run_en !== (c <= 12)) begin
                failures++;
                $display("FAIL nom_run c=%0d got %b exp %b", c, run_en, c <= 12);
            end
            tick();
        end
        beat = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL nom_end busy=%b done=%b err=%b exp 0", busy, done, err);
        end
    endtask

    task automatic test_bad_cfg();
        logic [7:0] bad [2];
        bad[0] = 8'd0;
        bad[1] = 8'd11;
        for (int i = 0; i < 2; i++) begin
            issue(bad[i], 1'b0, 16'd2);
            checks++;
            if (err !== 1'b1 || err_code !== 3'd1) begin
                failures++;
                $display("FAIL bad_err ks=%0d err=%b code=%0d exp 1/1", bad[i], err, err_code);
            end
            checks++;
            if (flush_tag !== 1'b0 || flush_kernel !== 1'b0) begin
                failures++;
                $display("FAIL bad_flush ks=%0d got %b%b exp 00", bad[i], flush_tag, flush_kernel);
            end
            tick();
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || kernel_size !== 8'd3 || external !== 1'b1) begin
                failures++;
                $display("FAIL bad_after err=%b busy=%b ks=%0d ext=%b exp 0/0/3/1",
                    err, busy, kernel_size, external);
            end
        end
    endtask

    task automatic test_rst_timeout();
        rst_busy = 1'b1;
        issue(8'd10, 1'b0, 16'd1);
        checks++;
        if (err_code !== 3'd0 || kernel_size !== 8'd10) begin
            failures++;
            $display("FAIL rto_start code=%0d ks=%0d exp 0/10", err_code, kernel_size);
        end
        for (int c = 1; c <= 17; c++) begin
            checks++;
            if (err !== (c == 17) || flush_tag !== 1'b0) begin
                failures++;
                $display("FAIL rto_seq c=%0d err=%b ft=%b exp %b/0", c, err, flush_tag, c == 17);
            end
            if (c < 17) tick();
        end
        checks++;
        if (err_code !== 3'd2) begin
            failures++;
            $display("FAIL rto_code got %0d exp 2", err_code);
        end
        rst_busy = 1'b0;
        tick();
    endtask

    task automatic test_tag_timeout();
        tag_busy = 1'b1;
        issue(8'd5, 1'b0, 16'd2);
        for (int c = 1; c <= 19; c++) begin
            checks++;
            if (err !== (c == 19) || flush_kernel !== 1'b0) begin
                failures++;
                $display("FAIL tto_seq c=%0d err=%b fk=%b exp %b/0", c, err, flush_kernel, c == 19);
            end
            if (c < 19) tick();
        end
        checks++;
        if (err_code !== 3'd3) begin
            failures++;
            $display("FAIL tto_code got %0d exp 3", err_code);
        end
        tag_busy = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL tto_idle busy=%b err=%b exp 0/0", busy, err);
        end
    endtask

    task automatic test_slow_busy(input logic [15:0] len);
        issue(8'd1, 1'b0, len);
        for (int c = 1; c <= 13; c++) begin
            kernel_busy = (c >= 6) && (c <= 10);
            beat = (c == 12);
            checks++;
            if (run_en !== ((len != 16'd0) && (c == 12))) begin
                failures++;
                $display("FAIL slow_run len=%0d c=%0d got %b", len, c, run_en);
            end
            checks++;
            if (done !== ((len == 16'd0) ? (c == 12) : (c == 13))) begin
                failures++;
                $display("FAIL slow_done len=%0d c=%0d got %b", len, c, done);
            end
            tick();
        end
        kernel_busy = 1'b0;
        beat = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL slow_idle len=%0d busy=%b exp 0", len, busy);
        end
    endtask

    task automatic test_abort();
        issue(8'd4, 1'b0, 16'd4);
        repeat (7) tick();
        beat = 1'b1;
        tick();
        tick();
        beat = 1'b0;
        abort = 1'b1;
        checks++;
        if (run_en !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre run_en=%b exp 1", run_en);
        end
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || err_code !== 3'd5 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_run busy=%b err=%b code=%0d done=%b exp 0/1/5/0",
                busy, err, err_code, done);
        end
        tick();
        checks++;
        if (err !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_after err=%b done=%b exp 0/0", err, done);
        end
        issue(8'd2, 1'b1, 16'd2);
        checks++;
        if (err_code !== 3'd0) begin
            failures++;
            $display("FAIL abort_clr code=%0d exp 0", err_code);
        end
        repeat (7) tick();
        beat = 1'b1;
        tick();
        tick();
        beat = 1'b0;
        checks++;
        if (done !== 1'b1 || kernel_size !== 8'd2) begin
            failures++;
            $display("FAIL abort_rerun done=%b ks=%0d exp 1/2", done, kernel_size);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (err !== 1'b0 || err_code !== 3'd5) begin
            failures++;
            $display("FAIL abort_idle err=%b code=%0d exp 0/5", err, err_code);
        end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        issue(8'd6, 1'b1, 16'd3);
        tick();
        checks++;
        if (flush_tag !== 1'b1) begin
            failures++;
            $display("FAIL rmf_pre flush_tag=%b exp 1", flush_tag);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({flush_tag, flush_kernel, run_en, busy, done, err, external, kernel_size, err_code} !== 18'd0) begin
            failures++;
            $display("FAIL rmf_outs ft=%b busy=%b ks=%0d exp 0", flush_tag, busy, kernel_size);
        end
        #1 rstn = 1'b1;
        tick();
        beat = 1'b1;
        repeat (3) tick();
        beat = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_beat busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_ignore_start();
        issue(8'd7, 1'b0, 16'd3);
        repeat (7) tick();
        for (int c = 8; c <= 12; c++) begin
            beat = (c <= 10);
            start = (c == 8) || (c == 9);
            cfg_kernel_size = 8'd0;
            checks++;
            if (done !== (c == 11) || err !== 1'b0) begin
                failures++;
                $display("FAIL ign_seq c=%0d done=%b err=%b exp %b/0", c, done, err, c == 11);
            end
            tick();
        end
        start = 1'b0;
        beat = 1'b0;
        checks++;
        if (busy !== 1'b0 || kernel_size !== 8'd7 || err_code !== 3'd0) begin
            failures++;
            $display("FAIL ign_end busy=%b ks=%0d code=%0d exp 0/7/0", busy, kernel_size, err_code);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_cfg();
        test_rst_timeout();
        test_tag_timeout();
        test_slow_busy(16'd1);
        test_slow_busy(16'd0);
        test_abort();
        test_reset_mid_flush();
        test_ignore_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
